arbiter_client: RTL and testbench

ARBITER_CLIENT -- requirements
Module: arbiter_client

---
 rtl/arbiter_client_pkg.sv | 20 ++
 rtl/arbiter_backoff_timer.sv | 36 +++
 rtl/arbiter_client.sv | 129 ++++++++++++
 tb/tb_arbiter_client.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_client_pkg.sv
// Shared definitions for arbiter_client: FSM state encoding, default parameters
// and a sizing helper for the backoff timer.
package arbiter_client_pkg;

    localparam int unsigned DEFAULT_LEN_WIDTH = 5;
    localparam int unsigned DEFAULT_BACKOFF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_BACKOFF = 2'd3
    } state_e;

    // Width able to hold (cycles - 1); the timer counts down to zero.
    function automatic int unsigned backoff_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/arbiter_backoff_timer.sv
// Backoff down-counter: load sets the start value, enable counts down to zero,
// expired is high while the count is zero.
module arbiter_backoff_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] count_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = count_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/arbiter_client.sv
// Arbiter client: accepts a job of job_len beats, requests the arbiter and moves one
// beat per granted cycle, backing off after preemption. ARBITER_CLIENT_STATS_EN adds preempt_count.
module arbiter_client
    import arbiter_client_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = DEFAULT_LEN_WIDTH,
    parameter int unsigned BACKOFF   = DEFAULT_BACKOFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_valid,
    input  logic [LEN_WIDTH-1:0] job_len,
    output logic                 job_ready,
    output logic                 request,
    input  logic                 grant,
    output logic                 beat,
    output logic [LEN_WIDTH-1:0] remaining,
`ifdef ARBITER_CLIENT_STATS_EN
    output logic [7:0]           preempt_count,
`endif
    output logic                 done
);

    localparam int unsigned     TW         = backoff_width(BACKOFF);
    // Loaded with BACKOFF-1 so that BACKOFF cycles elapse before the count reads zero.
    localparam logic [TW-1:0]   TIMER_LOAD = (BACKOFF > 0) ? TW'(BACKOFF - 1) : '0;

    state_e               state_q;
    logic                 request_q;
    logic                 done_q;
    logic [LEN_WIDTH-1:0] remaining_q;

    logic last_beat;
    logic preempt;
    logic timer_load;
    logic timer_en;
    logic timer_expired;

    always_comb begin
        last_beat  = (remaining_q == LEN_WIDTH'(1));
        preempt    = (state_q == ST_XFER) && !grant && (remaining_q != '0);
        timer_load = preempt && (BACKOFF != 0);
        timer_en   = (state_q == ST_BACKOFF);
    end

    arbiter_backoff_timer #(
        .WIDTH (TW)
    ) u_backoff_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (timer_load),
        .count_value (TIMER_LOAD),
        .enable      (timer_en),
        .expired     (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            request_q   <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (job_valid) begin
                        if (job_len != '0) begin
                            remaining_q <= job_len;
                            request_q   <= 1'b1;
                            state_q     <= ST_REQ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_REQ, ST_XFER: begin
                    if (beat) begin
                        if (remaining_q != '0) begin
                            remaining_q <= remaining_q - LEN_WIDTH'(1);
                        end
                        if (last_beat) begin
                            state_q   <= ST_IDLE;
                            request_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= ST_XFER;
                        end
                    end else if (preempt) begin
                        if (BACKOFF == 0) begin
                            state_q <= ST_REQ;
                        end else begin
                            state_q   <= ST_BACKOFF;
                            request_q <= 1'b0;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (timer_expired) begin
                        state_q   <= ST_REQ;
                        request_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ARBITER_CLIENT_STATS_EN
    logic [7:0] preempt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preempt_q <= '0;
        end else if (preempt && (preempt_q != '1)) begin
            preempt_q <= preempt_q + 8'd1;
        end
    end

    assign preempt_count = preempt_q;
`endif

    assign job_ready = (state_q == ST_IDLE);
    assign request   = request_q;
    assign beat      = request_q & grant;
    assign remaining = remaining_q;
    assign done      = done_q;

endmodule

// File: tb/tb_arbiter_client.sv
// Directed bench for arbiter_client (LEN_WIDTH=5, BACKOFF=2), plus three clients
// sharing a round-robin arbiter with a 5-cycle grant timeout.
module tb_arbiter_client;

    localparam int TIMEOUT = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       job_valid;
    logic [4:0] job_len;
    logic       job_ready;
    logic       request;
    logic       grant;
    logic       beat;
    logic [4:0] remaining;
    logic       done;
`ifdef ARBITER_CLIENT_STATS_EN
    logic [7:0] preempt_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arbiter_client #(
        .LEN_WIDTH (5),
        .BACKOFF   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_len       (job_len),
        .job_ready     (job_ready),
        .request       (request),
        .grant         (grant),
        .beat          (beat),
        .remaining     (remaining),
`ifdef ARBITER_CLIENT_STATS_EN
        .preempt_count (preempt_count),
`endif
        .done          (done)
    );

    // Three clients on a shared arbiter
    logic [2:0] m_valid;
    logic [2:0] m_ready;
    logic [2:0] m_req;
    logic [2:0] m_gnt = '0;
    logic [2:0] m_beat;
    logic [2:0] m_done;
    logic [4:0] m_len [3];
    logic [4:0] m_rem [3];
`ifdef ARBITER_CLIENT_STATS_EN
    logic [7:0] m_pc [3];
`endif

    for (genvar i = 0; i < 3; i++) begin : g_client
        arbiter_client #(
            .LEN_WIDTH (5),
            .BACKOFF   (2)
        ) u_client (
            .clk           (clk),
            .rst_n         (rst_n),
            .job_valid     (m_valid[i]),
            .job_len       (m_len[i]),
            .job_ready     (m_ready[i]),
            .request       (m_req[i]),
            .grant         (m_gnt[i]),
            .beat          (m_beat[i]),
            .remaining     (m_rem[i]),
`ifdef ARBITER_CLIENT_STATS_EN
            .preempt_count (m_pc[i]),
`endif
            .done          (m_done[i])
        );
    end

    logic [1:0] owner_q = 2'd0;
    logic [1:0] owner_d;
    logic [1:0] arb_idx;
    logic [2:0] gnt_d;
    int         hold_q = 0;
    int         hold_d;

    always_comb begin
        gnt_d   = '0;
        owner_d = owner_q;
        hold_d  = 0;
        arb_idx = '0;
        if (((m_gnt & m_req) != '0) && (hold_q < TIMEOUT - 1)) begin
            gnt_d  = m_gnt;
            hold_d = hold_q + 1;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                arb_idx = 2'((32'(owner_q) + k) % 3);
                if ((gnt_d == '0) && m_req[arb_idx]) begin
                    gnt_d[arb_idx] = 1'b1;
                    owner_d        = arb_idx;
                end
            end
        end
    end

    always @(posedge clk) begin
        m_gnt   <= gnt_d;
        owner_q <= owner_d;
        hold_q  <= hold_d;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int b_tot;
        int multi;
        int d_sum;
        int beats_i [3];
        int dones_i [3];

        rst_n     = 1'b0;
        job_valid = 1'b0;
        job_len   = '0;
        grant     = 1'b0;
        m_valid   = '0;
        for (int i = 0; i < 3; i++) m_len[i] = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ready", job_ready, 1);
        check_eq("rst_req", request, 0);
        check_eq("rst_rem", remaining, 0);
        check_eq("rst_done", done, 0);
`ifdef ARBITER_CLIENT_STATS_EN
        check_eq("rst_pc", preempt_count, 0);
`endif
        rst_n = 1'b1;

        // len=4, grant tied high
        @(negedge clk);
        job_valid = 1'b1; job_len = 5'd4; grant = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        check_eq("A_ready", job_ready, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("A_req", request, 1);
            check_eq("A_rem", remaining, 4 - k);
            check_eq("A_beat", beat, 1);
            check_eq("A_done_early", done, 0);
        end
        @(negedge clk);
        check_eq("A_req_end", request, 0);
        check_eq("A_rem_end", remaining, 0);
        check_eq("A_done", done, 1);
        check_eq("A_ready_done", job_ready, 1);
        check_eq("A_beat_end", beat, 0);
        grant = 1'b0;
        @(negedge clk);
        check_eq("A_done_pulse", done, 0);

        // len=6, three beats, preemption, backoff, regrant
        job_valid = 1'b1; job_len = 5'd6; grant = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("B_rem", remaining, 6 - k);
            check_eq("B_beat", beat, 1);
        end
        @(negedge clk);
        check_eq("B_rem3", remaining, 3);
        grant = 1'b0;
        @(negedge clk);
        check_eq("B_bo1_req", request, 0);
        check_eq("B_bo1_rem", remaining, 3);
        grant = 1'b1;
        @(negedge clk);
        check_eq("B_bo2_req", request, 0);
        check_eq("B_bo2_beat", beat, 0);
        check_eq("B_bo2_rem", remaining, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("B_re_req", request, 1);
            check_eq("B_re_rem", remaining, 3 - k);
            check_eq("B_re_beat", beat, 1);
        end
        @(negedge clk);
        check_eq("B_done", done, 1);
        check_eq("B_rem_end", remaining, 0);
        check_eq("B_req_end", request, 0);
`ifdef ARBITER_CLIENT_STATS_EN
        check_eq("B_pc", preempt_count, 1);
`endif
        grant = 1'b0;
        @(negedge clk);

        // len=0
        job_valid = 1'b1; job_len = 5'd0;
        @(negedge clk);
        job_valid = 1'b0;
        check_eq("C_done", done, 1);
        check_eq("C_req", request, 0);
        check_eq("C_ready", job_ready, 1);
        @(negedge clk);
        check_eq("C_done_pulse", done, 0);
        check_eq("C_req2", request, 0);

        // Back-to-back len=1 jobs with job_valid held
        job_valid = 1'b1; job_len = 5'd1; grant = 1'b1;
        @(negedge clk);
        check_eq("D_req", request, 1);
        check_eq("D_ready", job_ready, 0);
        @(negedge clk);
        check_eq("D_done1", done, 1);
        check_eq("D_ready1", job_ready, 1);
        @(negedge clk);
        job_valid = 1'b0;
        check_eq("D_req2", request, 1);
        check_eq("D_rem2", remaining, 1);
        @(negedge clk);
        check_eq("D_done2", done, 1);
        grant = 1'b0;

        // grant while idle ignored; job_valid during XFER ignored
        grant = 1'b1;
        @(negedge clk);
        check_eq("E_idle_req", request, 0);
        check_eq("E_idle_beat", beat, 0);
        check_eq("E_idle_rem", remaining, 0);
        check_eq("E_idle_done", done, 0);
        job_valid = 1'b1; job_len = 5'd3;
        @(negedge clk);
        job_len = 5'd7;
        check_eq("E_rem3", remaining, 3);
        @(negedge clk);
        check_eq("E_xfer_ready", job_ready, 0);
        check_eq("E_xfer_rem", remaining, 2);
        @(negedge clk);
        job_valid = 1'b0;
        check_eq("E_xfer_rem1", remaining, 1);
        @(negedge clk);
        check_eq("E_done", done, 1);
        check_eq("E_rem_end", remaining, 0);
        @(negedge clk);
        check_eq("E_no_reload", remaining, 0);
        check_eq("E_no_req", request, 0);

        // Reset during XFER with remaining=3
        job_valid = 1'b1; job_len = 5'd5;
        @(negedge clk);
        job_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("F_rem3", remaining, 3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("F_rst_req", request, 0);
        check_eq("F_rst_rem", remaining, 0);
        check_eq("F_rst_ready", job_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("F_post_done", done, 0);
            check_eq("F_post_req", request, 0);
            check_eq("F_post_rem", remaining, 0);
        end
        grant = 1'b0;

        // Three clients, len=10 each
        b_tot = 0; multi = 0; d_sum = 0;
        for (int i = 0; i < 3; i++) begin
            beats_i[i] = 0; dones_i[i] = 0; m_len[i] = 5'd10;
        end
        m_valid = 3'b111;
        @(negedge clk);
        m_valid = '0;
        for (int c = 0; c < 600 && d_sum < 3; c++) begin
            @(negedge clk);
            if ($countones(m_beat) > 1 || $countones(m_gnt) > 1) multi++;
            for (int i = 0; i < 3; i++) begin
                if (m_beat[i]) begin beats_i[i]++; b_tot++; end
                if (m_done[i]) begin dones_i[i]++; d_sum++; end
            end
        end
        check_eq("M_all_done", d_sum, 3);
        check_eq("M_total_beats", b_tot, 30);
        check_eq("M_overlap", multi, 0);
        for (int i = 0; i < 3; i++) begin
            check_eq("M_beats_i", beats_i[i], 10);
            check_eq("M_done_i", dones_i[i], 1);
            check_eq("M_rem_i", m_rem[i], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
